// File: rtl/rr_arb.sv
// Round-robin / fixed-priority arbiter with a registered one-hot grant held until accepted.
// Back-to-back re-arbitration on accept; the grant is withdrawn if its request drops.
module rr_arb #(
  parameter int unsigned REQ_NUM = 4,
  localparam int unsigned IDX_W = $clog2(REQ_NUM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REQ_NUM-1:0] req,
  input  logic               mode_rr,
  input  logic               grant_ready,
  output logic [REQ_NUM-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [REQ_NUM-1:0] grant_q;
  logic [IDX_W-1:0]   grant_idx_q;

  logic [IDX_W-1:0]   idle_idx;
  logic [IDX_W-1:0]   acc_ptr;
  logic [IDX_W-1:0]   acc_idx;
  logic [REQ_NUM-1:0] others;

  function automatic logic [IDX_W-1:0] lowest(input logic [REQ_NUM-1:0] r);
    lowest = '0;
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      if (r[i]) lowest = IDX_W'(i);
    end
  endfunction

  // Round-robin: lowest set bit at or above the pointer, else wrap to the lowest set bit overall.
  function automatic logic [IDX_W-1:0] pick(input logic [REQ_NUM-1:0] r, input logic rr,
                                            input logic [IDX_W-1:0] p);
    logic [REQ_NUM-1:0] upper;
    for (int i = 0; i < REQ_NUM; i++) begin
      upper[i] = r[i] && (i >= int'(p));
    end
    pick = (rr && (|upper)) ? lowest(upper) : lowest(r);
  endfunction

  function automatic logic [REQ_NUM-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction

  always_comb begin
    idle_idx = pick(req, mode_rr, ptr_q);
    acc_ptr  = (grant_idx_q == IDX_W'(REQ_NUM - 1)) ? '0 : grant_idx_q + IDX_W'(1);
    others   = req & ~grant_q;
    acc_idx  = pick(others, mode_rr, acc_ptr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      grant_q     <= '0;
      grant_idx_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            state_q     <= StGrant;
            grant_q     <= onehot(idle_idx);
            grant_idx_q <= idle_idx;
          end
        end
        StGrant: begin
          if (grant_valid && grant_ready) begin
            ptr_q <= acc_ptr;
            if (|others) begin
              grant_q     <= onehot(acc_idx);
              grant_idx_q <= acc_idx;
            end else begin
              state_q     <= StIdle;
              grant_q     <= '0;
              grant_idx_q <= '0;
            end
          end else if (!(|(req & grant_q))) begin
            // Requester withdrew before acceptance: drop the grant, pointer untouched.
            state_q     <= StIdle;
            grant_q     <= '0;
            grant_idx_q <= '0;
          end
        end
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = |grant_q;

endmodule

// File: tb/tb_rr_arb.sv
// Self-checking bench for rr_arb (REQ_NUM=4): directed scenarios plus randomized traffic
// compared against a cycle-level reference model of the arbitration rules.
module tb_rr_arb;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic         mode_rr = 1'b0;
  logic         grant_ready = 1'b0;
  logic [N-1:0] grant;
  logic [1:0]   grant_idx;
  logic         grant_valid;

  int checks = 0;
  int errors = 0;

  rr_arb #(.REQ_NUM(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .mode_rr     (mode_rr),
    .grant_ready (grant_ready),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; grant_ready = 1'b0; mode_rr = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  // Reference choice: scan requesters in policy order, -1 if nobody is requesting.
  function automatic int choose(input logic [N-1:0] r, input bit rr, input int p);
    for (int k = 0; k < N; k++) begin
      int j;
      j = rr ? (p + k) % N : k;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; grant_ready = 1'b1; mode_rr = 1'b1;
    cyc(); cyc();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want 0000", grant); end
    checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", grant_idx); end
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", grant_valid); end
    checks++; if (dut.ptr_q !== 2'd0) begin errors++; $display("FAIL reset_ptr got %0d want 0", dut.ptr_q); end
    rst = 1'b0; req = 4'b0100; grant_ready = 1'b0;
    cyc();
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL reset_first_grant got %b want 0100", grant); end
  endtask

  task automatic test_fixed();
    do_reset();
    mode_rr = 1'b0; req = 4'b1010; grant_ready = 1'b1;
    cyc();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL fixed_first got %b want 0010", grant); end
    cyc();
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL fixed_second got %b want 1000", grant); end
    req = 4'b1000;
    cyc();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL fixed_idle got %b want 0000", grant); end
    checks++; if (dut.ptr_q !== 2'd0) begin errors++; $display("FAIL fixed_ptr got %0d want 0", dut.ptr_q); end
  endtask

  task automatic test_rr_fair();
    do_reset();
    mode_rr = 1'b1; req = 4'b1111; grant_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      checks++;
      if (grant_idx !== 2'(k % N) || grant !== 4'(1 << (k % N)) || grant_valid !== 1'b1) begin
        errors++;
        $display("FAIL rr_fair step %0d got idx %0d grant %b valid %b want idx %0d", k, grant_idx,
                 grant, grant_valid, k % N);
      end
    end
  endtask

  task automatic test_hold_wrap();
    do_reset();
    mode_rr = 1'b1; req = 4'b0100; grant_ready = 1'b1;
    cyc(); cyc();
    checks++; if (dut.ptr_q !== 2'd3) begin errors++; $display("FAIL hold_setup_ptr got %0d want 3", dut.ptr_q); end
    req = 4'b1001; grant_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL hold_stable cycle %0d got %b want 1000", k, grant); end
    end
    grant_ready = 1'b1;
    cyc();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL hold_wrap_grant got %b want 0001", grant); end
    checks++; if (dut.ptr_q !== 2'd0) begin errors++; $display("FAIL hold_wrap_ptr got %0d want 0", dut.ptr_q); end
  endtask

  task automatic test_withdraw();
    do_reset();
    mode_rr = 1'b1; req = 4'b0100; grant_ready = 1'b0;
    cyc();
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL withdraw_setup got %b want 0100", grant); end
    req = 4'b0011;
    cyc();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL withdraw_drop got %b want 0000", grant); end
    checks++; if (dut.ptr_q !== 2'd0) begin errors++; $display("FAIL withdraw_ptr got %0d want 0", dut.ptr_q); end
    cyc();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL withdraw_regrant got %b want 0001", grant); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode_rr = 1'b1; req = 4'b0010; grant_ready = 1'b1;
    cyc(); cyc();
    grant_ready = 1'b0;
    cyc();
    checks++;
    if (grant !== 4'b0010 || dut.ptr_q !== 2'd2) begin
      errors++; $display("FAIL rstmid_setup got grant %b ptr %0d want 0010 ptr 2", grant, dut.ptr_q);
    end
    rst = 1'b1;
    cyc();
    checks++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || dut.ptr_q !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_clear got grant %b valid %b ptr %0d want 0000 0 0", grant, grant_valid,
               dut.ptr_q);
    end
    rst = 1'b0; req = 4'b0110;
    cyc();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL rstmid_regrant got %b want 0010", grant); end
  endtask

  task automatic test_mode_hold();
    do_reset();
    mode_rr = 1'b1; req = 4'b1000; grant_ready = 1'b0;
    cyc();
    req = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      mode_rr = ~mode_rr;
      cyc();
      checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL mode_hold cycle %0d got %b want 1000", k, grant); end
    end
    grant_ready = 1'b1;
    cyc();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL mode_after_accept got %b want 0001", grant); end
    // Second decision where the two policies disagree.
    do_reset();
    mode_rr = 1'b0; req = 4'b0010; grant_ready = 1'b0;
    cyc();
    req = 4'b1011; mode_rr = 1'b1;
    cyc();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL mode_no_preempt got %b want 0010", grant); end
    grant_ready = 1'b1;
    cyc();
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL mode_new_policy got %b want 1000", grant); end
  endtask

  task automatic test_random();
    int           g, p;
    logic [N-1:0] r, rem, exp_grant;
    bit           rdy, rs, m;
    do_reset();
    g = -1; p = 0; m = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      r = 4'($urandom);
      if (g >= 0 && $urandom_range(0, 5) != 0) r[g] = 1'b1;
      rdy = 1'($urandom_range(0, 1));
      if (g >= 0 && !r[g]) rdy = 1'b0;
      rs = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 3) == 0) m = ~m;
      req = r; grant_ready = rdy; rst = rs; mode_rr = m;
      if (rs) begin
        g = -1; p = 0;
      end else if (g < 0) begin
        g = choose(r, m, p);
      end else if (rdy) begin
        rem = r; rem[g] = 1'b0;
        p = (g + 1) % N;
        g = choose(rem, m, p);
      end else if (!r[g]) begin
        g = -1;
      end
      cyc();
      exp_grant = (g < 0) ? 4'b0000 : 4'(1 << g);
      checks++;
      if (grant !== exp_grant || grant_idx !== 2'((g < 0) ? 0 : g) || grant_valid !== (g >= 0)) begin
        errors++;
        $display("FAIL random cycle %0d got grant %b idx %0d valid %b want grant %b", c, grant,
                 grant_idx, grant_valid, exp_grant);
      end
      checks++;
      if (dut.ptr_q !== 2'(p)) begin
        errors++; $display("FAIL random_ptr cycle %0d got %0d want %0d", c, dut.ptr_q, p);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr_fair();
    test_hold_wrap();
    test_withdraw();
    test_reset_mid();
    test_mode_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
